// File: rtl/mcrc_pkg.sv
// Shared definitions for multicore_run_controller: FSM state encoding and core-count limit.
package mcrc_pkg;

  localparam int unsigned MCRC_MAX_CORES = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LAUNCH  = 3'd1,
    RUN     = 3'd2,
    DONE    = 3'd3,
    TIMEOUT = 3'd4
  } state_t;

endpackage

// File: rtl/mcrc_sat_counter.sv
// Saturating up-counter with synchronous clear/enable and a compare of the
// next (incremented) value against a runtime limit (limit==0 never hits).
module mcrc_sat_counter #(
  parameter int unsigned WIDTH = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             hit
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] next_val;

  always_comb begin
    next_val = (count_q == '1) ? count_q : count_q + WIDTH'(1);
    hit      = (limit != '0) && (next_val == limit);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= next_val;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/multicore_run_controller.sv
// Run/completion controller for CORE_COUNT cores: launch pulse, sticky endop
// tracking, done/timeout reporting. Optional macro: MCRC_PER_CORE_STAMP_EN.
module multicore_run_controller
  import mcrc_pkg::*;
#(
  parameter int unsigned CORE_COUNT     = 2,
  parameter int unsigned CYC_WIDTH      = 24,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [CORE_COUNT-1:0] core_enable,
  input  logic [CORE_COUNT-1:0] endop_signal,
  output logic [CORE_COUNT-1:0] core_start,
  output logic                  busy,
  output logic                  done,
  output logic                  all_endop,
  output logic                  timeout,
  output logic [CORE_COUNT-1:0] done_mask,
  output logic [CYC_WIDTH-1:0]  cycle_count
`ifdef MCRC_PER_CORE_STAMP_EN
  ,
  output logic [CORE_COUNT*CYC_WIDTH-1:0] core_stamp
`endif
);

  if (CORE_COUNT < 1 || CORE_COUNT > MCRC_MAX_CORES) begin : g_bad_cfg
    $error("multicore_run_controller: CORE_COUNT out of range");
  end

  state_t                state_q, state_d;
  logic [CORE_COUNT-1:0] en_q;
  logic [CORE_COUNT-1:0] done_mask_q;
  logic [CORE_COUNT-1:0] fin;
  logic                  all_fin;
  logic                  done_q, done_d;
  logic                  start_acc;
  logic                  mask_upd;
  logic                  inc_en;
  logic                  limit_hit;

  mcrc_sat_counter #(
    .WIDTH (CYC_WIDTH)
  ) u_cycles (
    .clk    (clk),
    .reset  (reset),
    .clear  (start_acc),
    .enable (inc_en),
    .limit  (CYC_WIDTH'(TIMEOUT_CYCLES)),
    .count  (cycle_count),
    .hit    (limit_hit)
  );

  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    start_acc = 1'b0;
    mask_upd  = 1'b0;
    inc_en    = 1'b0;
    fin       = done_mask_q | (endop_signal & en_q);
    all_fin   = (fin == en_q);
    case (state_q)
      IDLE, DONE, TIMEOUT: begin
        if (start) begin
          start_acc = 1'b1;
          if (core_enable == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = LAUNCH;
          end
        end
      end
      LAUNCH: state_d = RUN;
      RUN: begin
        // abort freezes mask and counter; completion beats the increment
        if (abort) begin
          state_d = IDLE;
        end else begin
          mask_upd = 1'b1;
          if (all_fin) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            inc_en = 1'b1;
            if (limit_hit) state_d = TIMEOUT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      en_q        <= '0;
      done_mask_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (start_acc) begin
        en_q        <= core_enable;
        done_mask_q <= '0;
      end else if (mask_upd) begin
        done_mask_q <= fin;
      end
    end
  end

  assign core_start = (state_q == LAUNCH) ? en_q : '0;
  assign busy       = (state_q == LAUNCH) || (state_q == RUN);
  assign done       = done_q;
  assign all_endop  = (state_q == DONE);
  assign timeout    = (state_q == TIMEOUT);
  assign done_mask  = done_mask_q;

`ifdef MCRC_PER_CORE_STAMP_EN
  // Each stamp tracks cycle_count until its core finishes, then holds; shown only once finished.
  logic [CORE_COUNT-1:0] stamp_hit_unused;
  for (genvar i = 0; i < CORE_COUNT; i++) begin : g_stamp
    logic [CYC_WIDTH-1:0] stamp_cnt;
    mcrc_sat_counter #(
      .WIDTH (CYC_WIDTH)
    ) u_stamp (
      .clk    (clk),
      .reset  (reset),
      .clear  (start_acc),
      .enable (inc_en & en_q[i] & ~fin[i]),
      .limit  ('0),
      .count  (stamp_cnt),
      .hit    (stamp_hit_unused[i])
    );
    assign core_stamp[i*CYC_WIDTH +: CYC_WIDTH] = done_mask_q[i] ? stamp_cnt : '0;
  end
`endif

endmodule

// File: tb/tb_multicore_run_controller.sv
// Directed bench for multicore_run_controller (2-core with timeout, 4-core without).
module tb_multicore_run_controller;

  logic        clk;
  logic        reset;
  logic        start2, abort2;
  logic [1:0]  en2, endop2, cs2, dm2;
  logic        busy2, done2, ae2, to2;
  logic [23:0] cc2;
  logic        start4, abort4;
  logic [3:0]  en4, endop4, cs4, dm4;
  logic        busy4, done4, ae4, to4;
  logic [23:0] cc4;
`ifdef MCRC_PER_CORE_STAMP_EN
  logic [47:0] stamp2;
  logic [95:0] stamp4;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  multicore_run_controller #(
    .CORE_COUNT     (2),
    .CYC_WIDTH      (24),
    .TIMEOUT_CYCLES (10)
  ) dut2 (
    .clk          (clk),
    .reset        (reset),
    .start        (start2),
    .abort        (abort2),
    .core_enable  (en2),
    .endop_signal (endop2),
    .core_start   (cs2),
    .busy         (busy2),
    .done         (done2),
    .all_endop    (ae2),
    .timeout      (to2),
    .done_mask    (dm2),
    .cycle_count  (cc2)
`ifdef MCRC_PER_CORE_STAMP_EN
    ,
    .core_stamp   (stamp2)
`endif
  );

  multicore_run_controller #(
    .CORE_COUNT     (4),
    .CYC_WIDTH      (24),
    .TIMEOUT_CYCLES (0)
  ) dut4 (
    .clk          (clk),
    .reset        (reset),
    .start        (start4),
    .abort        (abort4),
    .core_enable  (en4),
    .endop_signal (endop4),
    .core_start   (cs4),
    .busy         (busy4),
    .done         (done4),
    .all_endop    (ae4),
    .timeout      (to4),
    .done_mask    (dm4),
    .cycle_count  (cc4)
`ifdef MCRC_PER_CORE_STAMP_EN
    ,
    .core_stamp   (stamp4)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0;
    start2 = 1'b0; abort2 = 1'b0; en2 = '0; endop2 = '0;
    start4 = 1'b0; abort4 = 1'b0; en4 = '0; endop4 = '0;
    tick(); tick();
    chk("rst_busy", busy2, 1'b0);
    chk("rst_cs", cs2, 2'b00);
    chk("rst_cc", cc2, 24'd0);
    chk("rst_dm", dm2, 2'b00);
    chk("rst_done", done2, 1'b0);
    chk("rst_ae", ae2, 1'b0);
    chk("rst_to", to2, 1'b0);
    reset = 1'b1;

    // Both cores finish together on RUN cycle 4
    en2 = 2'b11; start2 = 1'b1;
    tick();
    chk("a_launch_cs", cs2, 2'b11);
    chk("a_launch_busy", busy2, 1'b1);
    start2 = 1'b0;
    tick();
    chk("a_c0_cs", cs2, 2'b00);
    repeat (4) tick();
    endop2 = 2'b11;
    tick();
    chk("a_done", done2, 1'b1);
    chk("a_ae", ae2, 1'b1);
    chk("a_cc", cc2, 24'd4);
    chk("a_dm", dm2, 2'b11);
    chk("a_busy", busy2, 1'b0);
    endop2 = 2'b00;
    tick();
    chk("a_done_pulse", done2, 1'b0);
    chk("a_ae_hold", ae2, 1'b1);

    // Staggered completion: core0 at cycle 2, core1 at cycle 7
    start2 = 1'b1;
    tick();
    chk("b_ae_clr", ae2, 1'b0);
    chk("b_dm_clr", dm2, 2'b00);
    chk("b_cc_clr", cc2, 24'd0);
    start2 = 1'b0;
    tick();
    repeat (2) tick();
    endop2 = 2'b01;
    tick();
    endop2 = 2'b00;
    chk("b_dm_c3", dm2, 2'b01);
    repeat (3) tick();
    chk("b_dm_c6", dm2, 2'b01);
    chk("b_cc_c6", cc2, 24'd6);
    tick();
    endop2 = 2'b10;
    tick();
    endop2 = 2'b00;
    chk("b_done", done2, 1'b1);
    chk("b_cc", cc2, 24'd7);
    chk("b_dm", dm2, 2'b11);
`ifdef MCRC_PER_CORE_STAMP_EN
    chk("b_stamp", stamp2, {24'd7, 24'd2});
`endif

    // Timeout after 10 run cycles with only core0 finished
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    tick();
    endop2 = 2'b01;
    tick();
    endop2 = 2'b00;
    repeat (8) tick();
    chk("c_c9_to", to2, 1'b0);
    chk("c_c9_cc", cc2, 24'd9);
    tick();
    chk("c_to", to2, 1'b1);
    chk("c_cc", cc2, 24'd10);
    chk("c_dm", dm2, 2'b01);
    chk("c_busy", busy2, 1'b0);
    chk("c_done", done2, 1'b0);
    tick();
    chk("c_to_hold", to2, 1'b1);
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    chk("c_relaunch_to", to2, 1'b0);
    chk("c_relaunch_cs", cs2, 2'b11);
    chk("c_relaunch_cc", cc2, 24'd0);

    // Abort on RUN cycle 3 with a simultaneous start
    tick();
    repeat (3) tick();
    abort2 = 1'b1; start2 = 1'b1;
    tick();
    abort2 = 1'b0; start2 = 1'b0;
    chk("d_busy", busy2, 1'b0);
    chk("d_cc", cc2, 24'd3);
    chk("d_done", done2, 1'b0);
    chk("d_cs", cs2, 2'b00);
    tick();
    chk("d_busy2", busy2, 1'b0);
    chk("d_cc2", cc2, 24'd3);
    chk("d_ae", ae2, 1'b0);

    // Start with no cores enabled goes straight to DONE
    en2 = 2'b00; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    chk("e_done", done2, 1'b1);
    chk("e_ae", ae2, 1'b1);
    chk("e_cc", cc2, 24'd0);
    chk("e_cs", cs2, 2'b00);

    // Reset pulled low mid-RUN
    en2 = 2'b11; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    tick();
    tick();
    endop2 = 2'b01;
    tick();
    endop2 = 2'b00;
    tick();
    chk("f_pre_dm", dm2, 2'b01);
    chk("f_pre_cc", cc2, 24'd3);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("f_busy", busy2, 1'b0);
    chk("f_cs", cs2, 2'b00);
    chk("f_cc", cc2, 24'd0);
    chk("f_dm", dm2, 2'b00);

    // Four cores, subset 0101; endop on disabled cores ignored
    en4 = 4'b0101; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    chk("g_cs", cs4, 4'b0101);
    tick();
    endop4 = 4'b1010;
    tick();
    chk("g_dm_ign", dm4, 4'b0000);
    chk("g_busy", busy4, 1'b1);
    chk("g_done0", done4, 1'b0);
    endop4 = 4'b0001;
    tick();
    chk("g_dm_c2", dm4, 4'b0001);
    endop4 = 4'b0100;
    tick();
    endop4 = 4'b0000;
    chk("g_done", done4, 1'b1);
    chk("g_cc", cc4, 24'd2);
    chk("g_dm", dm4, 4'b0101);
    chk("g_ae", ae4, 1'b1);
`ifdef MCRC_PER_CORE_STAMP_EN
    chk("g_stamp", stamp4, {24'd0, 24'd2, 24'd0, 24'd1});
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/multicore_run_controller.md
Name: multicore_run_controller

Overview:
- Parametrised run/completion controller for an N-core processor array; generalises the fixed two-core start/endop handshake to CORE_COUNT cores.
- Distributes a launch pulse to a selectable subset of cores and tracks per-core end-of-operation.
- Raises a single completion or timeout indication and reports elapsed run cycles.
- Sits between the system-level start/reset and the core array; it also gives benches one "all finished" signal to stop on.

Parameters:
- CORE_COUNT, 2, number of cores supervised (1..32).
- CYC_WIDTH, 24, width of the run-cycle counter.
- TIMEOUT_CYCLES, 0, run-cycle limit before timeout; 0 disables timeout.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset: reset==0 at a rising clk edge resets the block.
- start  input  1  launch request, sampled each cycle.
- abort  input  1  cancels a run in progress.
- core_enable  input  CORE_COUNT  cores taking part; latched when a start is accepted.
- endop_signal  input  CORE_COUNT  per-core end-of-operation; may be a pulse or a level.
- core_start  output  CORE_COUNT  one-cycle launch pulse to each enabled core.
- busy  output  1  high in LAUNCH and RUN.
- done  output  1  one-cycle pulse on entry to DONE.
- all_endop  output  1  level; high in DONE until the next accepted start or reset.
- timeout  output  1  level; high in TIMEOUT.
- done_mask  output  CORE_COUNT  sticky per-core finished flags for the current run.
- cycle_count  output  CYC_WIDTH  run cycles elapsed.

Behaviour:
- Reset (reset==0): state IDLE; all outputs 0, including core_start, done_mask and cycle_count. Reset overrides every other input in every state, including mid-run.
- States: IDLE, LAUNCH, RUN, DONE, TIMEOUT.
- Start acceptance (IDLE, DONE or TIMEOUT, start==1):
  - Latch core_enable into en_q.
  - Clear done_mask, cycle_count, all_endop and timeout.
  - If core_enable==0, go directly to DONE; done pulses and cycle_count stays 0.
  - Otherwise go to LAUNCH.
- start while busy: ignored.
- LAUNCH (exactly one cycle): core_start = en_q; go to RUN. endop_signal is not sampled in LAUNCH.
- RUN, each cycle:
  - fin = done_mask | (endop_signal & en_q); done_mask <= fin.
  - endop from non-enabled cores is ignored.
- RUN exit priority, highest first:
  1. abort==1: go to IDLE. done_mask is held, no done pulse, cycle_count is frozen.
  2. fin == en_q: go to DONE. cycle_count is not incremented on this cycle.
  3. Otherwise cycle_count increments, saturating at all-ones. If TIMEOUT_CYCLES!=0 and the incremented value equals TIMEOUT_CYCLES, go to TIMEOUT.
- Latency: endop_signal arriving on RUN cycle k (k counted from 0) gives done high on cycle k+1 and cycle_count==k.
- DONE: done high on the entry cycle only; all_endop held high. Leaves only on an accepted start or on reset.
- TIMEOUT: timeout held high; done_mask shows which cores finished. Leaves only on an accepted start or on reset.
- abort outside RUN: ignored.
- Cores that finish simultaneously are handled identically to staggered completion; the sticky mask tolerates endop pulses of any width and ordering.

Optional Feature:
- Macro: MCRC_PER_CORE_STAMP_EN.
- When defined:
  - Extra output core_stamp, width CORE_COUNT*CYC_WIDTH.
  - Slice i captures cycle_count on the first RUN cycle where core i's bit of fin rises.
  - Slices clear on reset and on an accepted start.
  - Slices of non-enabled cores stay 0.
- When undefined: no port and no stamp registers; all other behaviour is identical.

Decomposition:
- Shared package mcrc_pkg: state encoding enum (IDLE=0, LAUNCH=1, RUN=2, DONE=3, TIMEOUT=4, 3 bits) and a localparam for the maximum CORE_COUNT.
- One natural sub-module, mcrc_sat_counter: parametrised CYC_WIDTH saturating counter with clear, enable and equality-compare-to-limit output. It is reused for cycle_count and for the per-core stamp logic.

Test Plan:
- Reset pulled low mid-RUN with CORE_COUNT=2 → next cycle: state IDLE, core_start=0, busy=0, cycle_count=0, done_mask=0.
- core_enable=2'b11, start, both endop pulsed on RUN cycle 4 → core_start=2'b11 for exactly one cycle; done pulses one cycle; all_endop=1; cycle_count=4.
- core_enable=2'b11; core0 endop on RUN cycle 2 (one-cycle pulse), core1 endop on RUN cycle 7 → done_mask=2'b01 from cycle 3 until completion; done with cycle_count=7; with the macro defined, core_stamp={7,2}.
- CORE_COUNT=4, core_enable=4'b0101, endop only on cores 0 and 2 → done asserts; endop pulses on cores 1 and 3 have no effect.
- TIMEOUT_CYCLES=10, core_enable=2'b11, only core0 finishes → timeout=1 with cycle_count=10 and done_mask=2'b01; a new start clears timeout and relaunches.
- abort on RUN cycle 3 → IDLE, no done pulse, cycle_count=3; start asserted in the same cycle as abort is ignored.
